lfsr_step_sched: RTL and testbench
==================================

Name: lfsr_step_sched

Overview:
- Scheduler and sequencer for the 5-bit pseudo-random bit source used by the modulation datapath.
- Owns a 5-bit Fibonacci LFSR with an enable, plus a programmable rate divider and a run/pause/idle control FSM.
- Emits the current random state, a serial random bit, and per-step/per-period strobes for downstream modulation-select logic.

Parameters:
- DIV_W, 32, width of the rate divider counter and of div_val.
- SEED, 5'b00001, LFSR load value on reset, on return to IDLE and on lock-up recovery; must be nonzero.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; IDLE/PAUSE -> RUN.
- stop  in  1  level; RUN -> PAUSE, PAUSE -> IDLE.
- step_req  in  1  single-step request; honoured in IDLE and PAUSE only.
- div_val  in  DIV_W  step interval minus 1, in clk cycles; sampled live.
- lfsr_q  out  5  current LFSR state.
- rand_bit  out  1  equals lfsr_q[0].
- step_pulse  out  1  high for exactly the first cycle a new lfsr_q value is visible.
- seq_wrap  out  1  high with the step_pulse that completes a 31-step period.
- step_count  out  5  steps since last seed load, modulo 31 (range 0..30).
- busy  out  1  high when the FSM is in RUN.
- lockup_err  out  1  sticky; set on all-zero state detection; cleared only by reset.

Behaviour:
- Reset (overrides all inputs, also mid-run):
  - lfsr_q = SEED; divider count = 0; FSM = IDLE.
  - step_pulse, seq_wrap, step_count, busy and lockup_err all = 0.
- LFSR step rule: next = {q[0]^q[2], q[4:1]}.
  - Period is 31.
  - From 00001: 10000, 01000, 00100, 10010, 01001, 10100, ...
- Lock-up: if a step is taken while lfsr_q == 00000, load SEED instead and set lockup_err. This state is unreachable in normal operation.
- FSM states: IDLE, RUN, PAUSE.
  - stop has priority over start when both are high; start has priority over step_req.
  - IDLE: start -> RUN, with divider count cleared. step_req -> one step, stay IDLE. stop -> no effect.
  - RUN: the divider count increments each cycle. When count >= div_val, the edge clears count and steps the LFSR. stop -> PAUSE, holding count and lfsr_q (no step on that edge). step_req is ignored.
  - PAUSE: start -> RUN, resuming from the held count. step_req -> one step, stay PAUSE. stop -> IDLE, reloading SEED and clearing step_count and count.
- Latency: if start is sampled in IDLE at edge k, busy is high after edge k and the first LFSR step occurs at edge k+div_val+1. Steps then recur every div_val+1 cycles.
- div_val = 0: the LFSR steps every cycle in RUN, and step_pulse stays high continuously.
- div_val lowered below the current count: the step occurs on the next edge (>= compare).
- step_count and seq_wrap:
  - step_count increments on every step.
  - On the step taking step_count from 30 to 0, seq_wrap = 1 in the same cycle as step_pulse; lfsr_q is then back at SEED.
  - A lock-up recovery clears step_count to 0 and does not assert seq_wrap.
- Output timing: step_pulse and seq_wrap are registered and drop after one cycle unless another step occurs. All outputs are registered or are direct wires from registers.

Test Plan:
- Reset, div_val=3, pulse start one cycle -> busy=1. step_pulse every 4 cycles. lfsr_q = 10000, 01000, 00100, 10010, 01001, 10100. rand_bit tracks bit0.
- div_val=0, run 31 steps -> 31 distinct nonzero states. seq_wrap=1 only on step 31, with lfsr_q=00001 and step_count=0. lockup_err stays 0.
- div_val=9 in RUN, stop at count 5 -> PAUSE, lfsr_q frozen 20 cycles. step_req once -> exactly one step_pulse and step_count+1. start -> next step after 5 more cycles.
- In IDLE, start=stop=1 -> stays IDLE, busy=0. In PAUSE, stop -> IDLE with lfsr_q=00001 and step_count=0.
- Reset asserted mid-RUN after 7 steps -> after the edge: lfsr_q=00001, busy=0, step_count=0, no step_pulse.
- Force lfsr_q=00000 via testbench, then step_req -> lfsr_q=00001, lockup_err=1, which persists until reset.

Source files
------------

// File: rtl/lfsr_step_sched.sv
// lfsr_step_sched: 5-bit Fibonacci LFSR with a rate divider and an
// IDLE/RUN/PAUSE control FSM for the modulation random-bit source.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, stop       level controls (stop wins over start)
//   step_req          single step, honoured in IDLE and PAUSE
//   div_val           step interval minus 1, sampled live
//   lfsr_q, rand_bit  LFSR state and its bit 0
//   step_pulse        one cycle high when a new lfsr_q appears
//   seq_wrap          with the step that closes a 31-step period
//   step_count        steps since seed load, modulo 31
//   busy              FSM in RUN
//   lockup_err        sticky all-zero state flag
module lfsr_step_sched #(
  parameter int          DIV_W = 32,
  parameter logic [4:0]  SEED  = 5'b00001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step_req,
  input  logic [DIV_W-1:0] div_val,
  output logic [4:0]       lfsr_q,
  output logic             rand_bit,
  output logic             step_pulse,
  output logic             seq_wrap,
  output logic [4:0]       step_count,
  output logic             busy,
  output logic             lockup_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic             do_step;
  logic             reseed;
  logic             lock;
  logic [4:0]       lfsr_adv;
  logic [4:0]       cnt_adv;

  assign lfsr_adv = {lfsr_q[0] ^ lfsr_q[2], lfsr_q[4:1]};
  assign lock     = do_step && (lfsr_q == 5'd0);
  assign cnt_adv  = (step_count == 5'd30) ? 5'd0
                                          : step_count + 5'd1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    do_step   = 1'b0;
    reseed    = 1'b0;
    unique case (state)
      IDLE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (step_req) begin
          do_step = 1'b1;
        end
      end
      RUN: begin
        // stop freezes both count and LFSR for a later resume
        if (stop) begin
          state_nxt = PAUSE;
        end else if (cnt >= div_val) begin
          do_step = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + DIV_W'(1);
        end
      end
      PAUSE: begin
        if (stop) begin
          state_nxt = IDLE;
          reseed    = 1'b1;
          cnt_nxt   = '0;
        end else if (start) begin
          state_nxt = RUN;
        end else if (step_req) begin
          do_step = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lfsr_q     <= SEED;
      step_count <= 5'd0;
      step_pulse <= 1'b0;
      seq_wrap   <= 1'b0;
      lockup_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      step_pulse <= do_step;
      seq_wrap   <= do_step && !lock
                    && (step_count == 5'd30);
      if (reseed) begin
        lfsr_q     <= SEED;
        step_count <= 5'd0;
      end else if (lock) begin
        // all-zero state would stick forever; recover to seed
        lfsr_q     <= SEED;
        step_count <= 5'd0;
        lockup_err <= 1'b1;
      end else if (do_step) begin
        lfsr_q     <= lfsr_adv;
        step_count <= cnt_adv;
      end
    end
  end

  assign rand_bit = lfsr_q[0];
  assign busy     = (state == RUN);

endmodule

// File: tb/tb_lfsr_step_sched.sv
// tb_lfsr_step_sched: vector table, directed sequences and random
// stimulus checked against a behavioural model of lfsr_step_sched.
module tb_lfsr_step_sched;

  localparam logic [4:0] SEED = 5'b00001;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        step_req;
  logic [31:0] div_val;
  logic [4:0]  lfsr_q;
  logic        rand_bit;
  logic        step_pulse;
  logic        seq_wrap;
  logic [4:0]  step_count;
  logic        busy;
  logic        lockup_err;

  always #5 clk = ~clk;

  lfsr_step_sched #(.DIV_W(32), .SEED(SEED)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .step_req(step_req),
    .div_val(div_val),
    .lfsr_q(lfsr_q),
    .rand_bit(rand_bit),
    .step_pulse(step_pulse),
    .seq_wrap(seq_wrap),
    .step_count(step_count),
    .busy(busy),
    .lockup_err(lockup_err)
  );

  int checks = 0;
  int failures = 0;

  // behavioural model: mode 0=idle 1=run 2=pause
  int         m_mode;
  longint     m_cnt;
  logic [4:0] m_q;
  int         m_sc;
  bit         m_pulse;
  bit         m_wrap;
  bit         m_lock;

  function automatic logic [4:0] nxt(input logic [4:0] q);
    logic [4:0] fb;
    fb = ((q ^ (q >> 2)) & 5'd1) << 4;
    return fb | (q >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic m_step();
    if (m_q == 5'd0) begin
      m_q    = SEED;
      m_sc   = 0;
      m_lock = 1;
    end else begin
      m_q    = nxt(m_q);
      m_sc   = (m_sc + 1) % 31;
      m_wrap = (m_sc == 0);
    end
    m_pulse = 1;
  endtask

  task automatic model(input bit r, s, p, sr);
    m_pulse = 0;
    m_wrap  = 0;
    if (r) begin
      m_mode = 0; m_cnt = 0; m_q = SEED; m_sc = 0; m_lock = 0;
    end else if (m_mode == 0) begin
      if (p) begin
      end else if (s) begin
        m_mode = 1; m_cnt = 0;
      end else if (sr) m_step();
    end else if (m_mode == 1) begin
      if (p) m_mode = 2;
      else if (m_cnt >= longint'(div_val)) begin
        m_step(); m_cnt = 0;
      end else m_cnt++;
    end else begin
      if (p) begin
        m_mode = 0; m_q = SEED; m_sc = 0; m_cnt = 0;
      end else if (s) m_mode = 1;
      else if (sr) m_step();
    end
  endtask

  task automatic drive(input bit r, s, p, sr);
    reset = r; start = s; stop = p; step_req = sr;
    model(r, s, p, sr);
    @(posedge clk);
    #1;
    chk("model",
        32'({lfsr_q, rand_bit, step_pulse, seq_wrap,
             step_count, busy, lockup_err}),
        32'({m_q, m_q[0], m_pulse, m_wrap,
             5'(m_sc), (m_mode == 1), m_lock}));
  endtask

  typedef struct {
    bit         r;
    bit         s;
    logic [4:0] q;
    bit         p;
    bit         b;
    int         sc;
  } vec_t;

  vec_t       tv[26];
  logic [4:0] seqv[7];

  initial begin
    int n;
    int nd;
    bit [31:0] seen;
    bit frozen;

    seqv = '{5'b00001, 5'b10000, 5'b01000, 5'b00100,
             5'b10010, 5'b01001, 5'b10100};
    tv[0] = '{1, 0, 5'b00001, 0, 0, 0};
    tv[1] = '{0, 1, 5'b00001, 0, 1, 0};
    for (int i = 2; i < 26; i++) begin
      tv[i].r  = 0;
      tv[i].s  = 0;
      tv[i].b  = 1;
      tv[i].sc = (i - 1) / 4;
      tv[i].q  = seqv[(i - 1) / 4];
      tv[i].p  = (i >= 5) && ((i - 1) % 4 == 0);
    end

    reset = 1; start = 0; stop = 0; step_req = 0; div_val = 3;
    @(negedge clk);

    // div_val=3 start-up sequence
    for (int i = 0; i < 26; i++) begin
      drive(tv[i].r, tv[i].s, 0, 0);
      chk($sformatf("tv%0d_q", i), 32'(lfsr_q), 32'(tv[i].q));
      chk($sformatf("tv%0d_pulse", i), 32'(step_pulse), 32'(tv[i].p));
      chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].b));
      chk($sformatf("tv%0d_sc", i), 32'(step_count), 32'(tv[i].sc));
      chk($sformatf("tv%0d_bit", i), 32'(rand_bit), 32'(tv[i].q[0]));
    end

    // div_val=0: full period, one step per cycle
    div_val = 0;
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    seen = '0; nd = 0;
    for (int i = 0; i < 31; i++) begin
      drive(0, 0, 0, 0);
      if (!seen[lfsr_q] && lfsr_q != 0) nd++;
      seen[lfsr_q] = 1'b1;
      chk("p31_pulse", 32'(step_pulse), 32'd1);
      chk("p31_wrap", 32'(seq_wrap), 32'(i == 30));
    end
    chk("p31_distinct", 32'(nd), 32'd31);
    chk("p31_seed", 32'(lfsr_q), 32'(SEED));
    chk("p31_sc", 32'(step_count), 32'd0);
    chk("p31_lock", 32'(lockup_err), 32'd0);

    // pause at count 5, single step, resume
    div_val = 9;
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    chk("pause_busy", 32'(busy), 32'd0);
    frozen = 1;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0);
      if (lfsr_q !== SEED || step_pulse !== 1'b0) frozen = 0;
    end
    chk("pause_frozen", 32'(frozen), 32'd1);
    drive(0, 0, 0, 1);
    chk("sstep_pulse", 32'(step_pulse), 32'd1);
    chk("sstep_sc", 32'(step_count), 32'd1);
    chk("sstep_q", 32'(lfsr_q), 32'b10000);
    drive(0, 0, 0, 0);
    chk("sstep_drop", 32'(step_pulse), 32'd0);
    drive(0, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0);
      n++;
      if (step_pulse) break;
    end
    chk("resume_lat", 32'(n), 32'd5);

    // start+stop in IDLE, then PAUSE -> IDLE
    drive(1, 0, 0, 0);
    drive(0, 1, 1, 0);
    chk("ss_busy", 32'(busy), 32'd0);
    div_val = 0;
    drive(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    chk("pz_sc", 32'(step_count), 32'd3);
    drive(0, 0, 1, 0);
    chk("idle_q", 32'(lfsr_q), 32'(SEED));
    chk("idle_sc", 32'(step_count), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // reset mid-run after 7 steps
    drive(0, 1, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 0);
    chk("mr_sc7", 32'(step_count), 32'd7);
    drive(1, 0, 0, 0);
    chk("mr_q", 32'(lfsr_q), 32'(SEED));
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_sc", 32'(step_count), 32'd0);
    chk("mr_pulse", 32'(step_pulse), 32'd0);

    // forced lock-up recovery
    force dut.lfsr_q = 5'd0;
    #1;
    release dut.lfsr_q;
    m_q = 5'd0;
    drive(0, 0, 0, 1);
    chk("lk_q", 32'(lfsr_q), 32'(SEED));
    chk("lk_err", 32'(lockup_err), 32'd1);
    chk("lk_wrap", 32'(seq_wrap), 32'd0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
    chk("lk_sticky", 32'(lockup_err), 32'd1);
    drive(1, 0, 0, 0);
    chk("lk_clear", 32'(lockup_err), 32'd0);

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) div_val = $urandom_range(0, 5);
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 20);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
